// File: rtl/regbank_wr.sv
// regbank_wr: write side of the 32x32 register bank; one byte-masked write per clock, last-write record, commit count.
// Write latency 1 clock, no stall (a write accepted every cycle); define REG0_ZERO_EN to hardwire R[0] to zero.

module regbank_wr (
   input  logic          clk,
   input  logic          clr,
   input  logic          WE,
   input  logic [4:0]    WA,
   input  logic [31:0]   WD,
   input  logic [3:0]    BE,
   output logic [1023:0] Q,
   output logic          LWV,
   output logic [4:0]    LWA,
   output logic [31:0]   LWD,
   output logic [15:0]   WCNT
);

`ifdef REG0_ZERO_EN
   localparam int FIRST_FLOP = 1;
`else
   localparam int FIRST_FLOP = 0;
`endif

   logic        commit;
   logic [31:0] byte_mask;
   logic [31:0] cur_word;
   logic [31:0] merged_word;

   logic        lwv_d, lwv_q;
   logic [4:0]  lwa_d, lwa_q;
   logic [31:0] lwd_d, lwd_q;
   logic [15:0] wcnt_d, wcnt_q;

   always_comb begin
      byte_mask   = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
      // Merge source is the flopped word, so back-to-back partial writes accumulate.
      cur_word    = Q[{WA, 5'd0} +: 32];
      merged_word = (cur_word & ~byte_mask) | (WD & byte_mask);
`ifdef REG0_ZERO_EN
      commit      = WE && (BE != 4'd0) && (WA != 5'd0);
`else
      commit      = WE && (BE != 4'd0);
`endif
   end

   always_comb begin
      lwv_d  = commit;
      lwa_d  = lwa_q;
      lwd_d  = lwd_q;
      wcnt_d = wcnt_q;
      if (commit) begin
         lwa_d  = WA;
         lwd_d  = merged_word;
         wcnt_d = wcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         lwv_q  <= 1'b0;
         lwa_q  <= 5'd0;
         lwd_q  <= 32'd0;
         wcnt_q <= 16'd0;
      end else begin
         lwv_q  <= lwv_d;
         lwa_q  <= lwa_d;
         lwd_q  <= lwd_d;
         wcnt_q <= wcnt_d;
      end
   end

`ifdef REG0_ZERO_EN
   assign Q[31:0] = 32'd0;
`endif

   for (genvar i = FIRST_FLOP; i < 32; i++) begin : g_word
      logic [31:0] word_d, word_q;

      always_comb begin
         word_d = word_q;
         if (commit && (WA == 5'(i))) begin
            word_d = merged_word;
         end
      end

      always_ff @(posedge clk) begin
         if (!clr) begin
            word_q <= 32'd0;
         end else begin
            word_q <= word_d;
         end
      end

      assign Q[32*i +: 32] = word_q;
   end

   assign LWV  = lwv_q;
   assign LWA  = lwa_q;
   assign LWD  = lwd_q;
   assign WCNT = wcnt_q;

endmodule

// File: tb/tb_regbank_wr.sv
// Bench for regbank_wr: scoreboard of per-cycle expected outputs from a word-array reference model.
// Honour REG0_ZERO_EN the same way the design build does.

module tb_regbank_wr;

   logic          clk = 1'b0;
   logic          clr;
   logic          we;
   logic [4:0]    wa;
   logic [31:0]   wd;
   logic [3:0]    be;
   logic [1023:0] q;
   logic          lwv;
   logic [4:0]    lwa;
   logic [31:0]   lwd;
   logic [15:0]   wcnt;

   regbank_wr dut (
      .clk  (clk),
      .clr  (clr),
      .WE   (we),
      .WA   (wa),
      .WD   (wd),
      .BE   (be),
      .Q    (q),
      .LWV  (lwv),
      .LWA  (lwa),
      .LWD  (lwd),
      .WCNT (wcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1023:0] q;
      logic          lwv;
      logic [4:0]    lwa;
      logic [31:0]   lwd;
      logic [15:0]   wcnt;
   } exp_t;

   exp_t sb[$];

   // Reference model: architectural state as plain variables.
   logic [31:0] mem [32];
   logic        m_lwv;
   logic [4:0]  m_lwa;
   logic [31:0] m_lwd;
   int          m_cnt;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_q(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int w = 0; w < 32; w++) begin
            if (act[32*w +: 32] !== exp[32*w +: 32]) begin
               $display("FAIL %s word %0d: got %h expected %h", name, w, act[32*w +: 32], exp[32*w +: 32]);
               break;
            end
         end
      end
   endtask

   function automatic void model_step(input logic c, input logic w, input logic [4:0] a,
                                      input logic [31:0] d, input logic [3:0] b);
      bit takes;
      if (!c) begin
         for (int i = 0; i < 32; i++) mem[i] = 32'd0;
         m_lwv = 1'b0;
         m_lwa = 5'd0;
         m_lwd = 32'd0;
         m_cnt = 0;
         return;
      end
      takes = w && (b != 4'd0);
`ifdef REG0_ZERO_EN
      if (a == 5'd0) takes = 1'b0;
`endif
      m_lwv = takes;
      if (takes) begin
         for (int k = 0; k < 4; k++) begin
            if (b[k]) mem[a][8*k +: 8] = d[8*k +: 8];
         end
         m_lwa = a;
         m_lwd = mem[a];
         m_cnt = (m_cnt + 1) % 65536;
      end
   endfunction

   function automatic logic [1023:0] model_q();
      logic [1023:0] v;
      for (int i = 0; i < 32; i++) v[32*i +: 32] = mem[i];
      return v;
   endfunction

   // Drive one cycle of inputs; after the edge, queue what the outputs must show.
   task automatic cycle(input logic c, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      exp_t e;
      clr = c; we = w; wa = a; wd = d; be = b;
      @(posedge clk);
      model_step(c, w, a, d, b);
      e.q    = model_q();
      e.lwv  = m_lwv;
      e.lwa  = m_lwa;
      e.lwd  = m_lwd;
      e.wcnt = 16'(m_cnt);
      sb.push_back(e);
      #2;
   endtask

   task automatic idle();
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 4'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk_q("sb_Q", q, e.q);
         chk("sb_LWV", 64'(lwv), 64'(e.lwv));
         chk("sb_LWA", 64'(lwa), 64'(e.lwa));
         chk("sb_LWD", 64'(lwd), 64'(e.lwd));
         chk("sb_WCNT", 64'(wcnt), 64'(e.wcnt));
      end
   end

   initial begin
      logic [31:0] old_word;
      int          old_cnt;
      for (int i = 0; i < 32; i++) mem[i] = 32'hX;
      m_lwv = 1'b0; m_lwa = 5'd0; m_lwd = 32'd0; m_cnt = 0;

      cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
      cycle(1'b0, 1'b1, 5'd9, 32'h5555_5555, 4'hF);
      chk_q("reset_Q", q, '0);
      chk("reset_LWV", 64'(lwv), 64'd0);
      chk("reset_WCNT", 64'(wcnt), 64'd0);

      // Reset sweep
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 5'(i), 32'hFFFF_FFFF, 4'hF);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
      chk_q("sweep_Q", q, '0);
      chk("sweep_WCNT", 64'(wcnt), 64'd0);
      chk("sweep_LWV", 64'(lwv), 64'd0);

      // Full then partial write to the same register
      cycle(1'b1, 1'b1, 5'd5, 32'h1234_5678, 4'hF);
      cycle(1'b1, 1'b1, 5'd5, 32'hAABB_CCDD, 4'b0101);
      chk("partial_Q5", 64'(q[191:160]), 64'h12BB_56DD);
      chk("partial_LWD", 64'(lwd), 64'h12BB_56DD);
      chk("partial_WCNT", 64'(wcnt), 64'd2);

      // Collision: old value visible during the commit cycle
      clr = 1'b1; we = 1'b1; wa = 5'd31; wd = 32'hDEAD_BEEF; be = 4'hF;
      #1;
      chk("collision_pre_Q31", 64'(q[1023:992]), 64'(mem[31]));
      cycle(1'b1, 1'b1, 5'd31, 32'hDEAD_BEEF, 4'hF);
      chk("collision_Q31", 64'(q[1023:992]), 64'hDEAD_BEEF);
      chk("collision_LWV", 64'(lwv), 64'd1);
      chk("collision_LWA", 64'(lwa), 64'd31);
      idle();
      chk("collision_LWV_drop", 64'(lwv), 64'd0);
      chk("collision_LWA_hold", 64'(lwa), 64'd31);

      // Null write
      cycle(1'b1, 1'b1, 5'd3, 32'h0BAD_F00D, 4'hF);
      old_word = mem[3];
      old_cnt  = m_cnt;
      cycle(1'b1, 1'b1, 5'd3, 32'h1111_2222, 4'h0);
      chk("null_Q3", 64'(q[127:96]), 64'(old_word));
      chk("null_LWV", 64'(lwv), 64'd0);
      chk("null_WCNT", 64'(wcnt), 64'(old_cnt));

      // Register 0
      old_cnt = m_cnt;
      cycle(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF);
`ifdef REG0_ZERO_EN
      chk("reg0_Q0", 64'(q[31:0]), 64'd0);
      chk("reg0_LWV", 64'(lwv), 64'd0);
      chk("reg0_WCNT", 64'(wcnt), 64'(old_cnt));
`else
      chk("reg0_Q0", 64'(q[31:0]), 64'hFFFF_FFFF);
      chk("reg0_LWV", 64'(lwv), 64'd1);
      chk("reg0_WCNT", 64'(wcnt), 64'(old_cnt + 1));
`endif

      // Reset mid-stream with a write presented
      cycle(1'b1, 1'b1, 5'd7, 32'hCAFE_0001, 4'hF);
      cycle(1'b0, 1'b1, 5'd7, 32'd1, 4'hF);
      chk("midrst_Q7", 64'(q[255:224]), 64'd0);
      chk("midrst_WCNT", 64'(wcnt), 64'd0);
      cycle(1'b1, 1'b1, 5'd7, 32'd5, 4'hF);
      chk("postrst_Q7", 64'(q[255:224]), 64'd5);
      chk("postrst_WCNT", 64'(wcnt), 64'd1);

      // Randomized traffic, including same-address bursts and occasional reset
      for (int n = 0; n < 600; n++) begin
         cycle(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
               $urandom, 4'($urandom));
      end

      // Counter wrap
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
      for (int n = 0; n < 65535; n++) begin
         cycle(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom, 4'($urandom_range(1, 15)));
      end
      chk("wrap_WCNT_max", 64'(wcnt), 64'hFFFF);
      cycle(1'b1, 1'b1, 5'd12, 32'h0000_0042, 4'hF);
      chk("wrap_WCNT_zero", 64'(wcnt), 64'd0);
      chk("wrap_LWV", 64'(lwv), 64'd1);

      idle();
      repeat (3) @(posedge clk);
      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
